// File: rtl/timer_bank_pkg.sv
// Shared command codes and channel state encoding for the timer bank.
package timer_bank_pkg;

  localparam logic [1:0] CMD_PERIOD = 2'b00;
  localparam logic [1:0] CMD_START  = 2'b01;
  localparam logic [1:0] CMD_STOP   = 2'b10;
  localparam logic [1:0] CMD_NOP    = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/timer_chan.sv
// One down-counting timer channel: periodic or one-shot, gated by i_en, registered tc pulse.
module timer_chan
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_stb,
  input  logic [1:0]       i_cmd,
  input  logic [WIDTH-1:0] i_period,
  input  logic             i_oneshot,
  input  logic             i_en,
  output logic             o_tc,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_count
);

  state_e           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_oneshot;
  logic             r_tc;

  logic w_start, w_stop, w_setp;

  assign w_start = i_cmd_stb && (i_cmd == CMD_START);
  assign w_stop  = i_cmd_stb && (i_cmd == CMD_STOP);
  assign w_setp  = i_cmd_stb && (i_cmd == CMD_PERIOD);

  // Commands take priority over counting; a reload reads the period before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_period  <= '0;
      r_oneshot <= 1'b0;
      r_tc      <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (w_start) begin
        r_period  <= i_period;
        r_oneshot <= i_oneshot;
        r_count   <= i_period;
        r_state   <= ST_RUN;
      end else if (w_stop) begin
        r_state <= ST_IDLE;
      end else begin
        if (w_setp) r_period <= i_period;
        if (r_state == ST_RUN && i_en) begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_tc <= 1'b1;
            if (r_oneshot) r_state <= ST_IDLE;
            else           r_count <= r_period;
          end
        end
      end
    end
  end

  assign o_tc    = r_tc;
  assign o_busy  = (r_state == ST_RUN);
  assign o_count = r_count;

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH programmable timers behind one valid/ready command port.
// Optional sticky status/irq outputs are built when TIMER_BANK_IRQ_EN is defined.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int CH_W  = (NCH > 1 ? $clog2(NCH) : 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [1:0]           cfg_cmd,
  input  logic [WIDTH-1:0]     cfg_period,
  input  logic                 cfg_oneshot,
  input  logic [NCH-1:0]       en,
  output logic [NCH-1:0]       tc,
  output logic [NCH-1:0]       busy,
  output logic [NCH*WIDTH-1:0] count
`ifdef TIMER_BANK_IRQ_EN
  ,
  input  logic [NCH-1:0]       irq_clr,
  output logic [NCH-1:0]       status,
  output logic                 irq
`endif
);

  logic r_ready;
  logic w_acc;

  always_ff @(posedge clk) begin
    if (rst) r_ready <= 1'b0;
    else     r_ready <= 1'b1;
  end

  assign cfg_ready = r_ready;
  // Out-of-range channel indices simply match no instance below.
  assign w_acc     = cfg_valid && r_ready && (cfg_cmd != CMD_NOP);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic w_stb;
    assign w_stb = w_acc && (cfg_ch == CH_W'(gi));

    timer_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .i_cmd_stb(w_stb),
      .i_cmd    (cfg_cmd),
      .i_period (cfg_period),
      .i_oneshot(cfg_oneshot),
      .i_en     (en[gi]),
      .o_tc     (tc[gi]),
      .o_busy   (busy[gi]),
      .o_count  (count[gi*WIDTH +: WIDTH])
    );
  end

`ifdef TIMER_BANK_IRQ_EN
  logic [NCH-1:0] r_status;
  logic           r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= (r_status & ~irq_clr) | tc;
      r_irq    <= |r_status;
    end
  end

  assign status = r_status;
  assign irq    = r_irq;
`endif

endmodule

// File: tb/tb_timer_bank.sv
// Directed table-driven bench for timer_bank (NCH=4) plus an NCH=3 instance for out-of-range commands.
module tb_timer_bank;
  import timer_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_cmd;
  logic [15:0] cfg_period;
  logic        cfg_oneshot;
  logic [3:0]  en;
  logic        cfg_ready, cfg_ready3;
  logic [3:0]  tc, busy;
  logic [63:0] count;
  logic [2:0]  tc3, busy3;
  logic [47:0] count3;
`ifdef TIMER_BANK_IRQ_EN
  logic [3:0] irq_clr = '0;
  logic [3:0] status;
  logic       irq;
  logic [2:0] irq_clr3 = '0;
  logic [2:0] status3;
  logic       irq3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timer_bank #(.WIDTH(16), .NCH(4)) u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_cmd(cfg_cmd), .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .en(en),
    .tc(tc), .busy(busy), .count(count)
`ifdef TIMER_BANK_IRQ_EN
    , .irq_clr(irq_clr), .status(status), .irq(irq)
`endif
  );

  timer_bank #(.WIDTH(16), .NCH(3)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch),
    .cfg_cmd(cfg_cmd), .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .en(en[2:0]),
    .tc(tc3), .busy(busy3), .count(count3)
`ifdef TIMER_BANK_IRQ_EN
    , .irq_clr(irq_clr3), .status(status3), .irq(irq3)
`endif
  );

  typedef struct {
    logic        v;
    logic [1:0]  ch;
    logic [1:0]  cmd;
    logic [15:0] per;
    logic        os;
    logic [3:0]  en;
    logic [1:0]  kch;
    logic [3:0]  etc;
    logic [3:0]  ebusy;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [1:0] ch, input logic [1:0] cmd,
                     input logic [15:0] per, input logic os, input logic [3:0] e,
                     input logic [1:0] kch, input logic [3:0] etc, input logic [3:0] eb,
                     input logic [15:0] ec);
    vec_t r;
    r.v = v; r.ch = ch; r.cmd = cmd; r.per = per; r.os = os; r.en = e;
    r.kch = kch; r.etc = etc; r.ebusy = eb; r.ecnt = ec;
    vecs.push_back(r);
  endtask

  task automatic idle(input logic [3:0] e, input logic [1:0] kch, input logic [3:0] etc,
                      input logic [3:0] eb, input logic [15:0] ec);
    add(1'b0, 2'd0, CMD_NOP, 16'd0, 1'b0, e, kch, etc, eb, ec);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_cmd = CMD_NOP;
    cfg_period = '0; cfg_oneshot = 1'b0; en = 4'hF;

    // Periodic P=3 on ch0, then PERIOD rewrites (including one on a reload cycle)
    add(1, 0, CMD_START, 3, 0, 4'hF, 0, 0, 1, 3);
    idle(4'hF, 0, 0, 1, 2); idle(4'hF, 0, 0, 1, 1); idle(4'hF, 0, 0, 1, 0);
    idle(4'hF, 0, 1, 1, 3); idle(4'hF, 0, 0, 1, 2); idle(4'hF, 0, 0, 1, 1);
    idle(4'hF, 0, 0, 1, 0); idle(4'hF, 0, 1, 1, 3);
    add(1, 0, CMD_PERIOD, 1, 0, 4'hF, 0, 0, 1, 2);
    idle(4'hF, 0, 0, 1, 1); idle(4'hF, 0, 0, 1, 0); idle(4'hF, 0, 1, 1, 1);
    idle(4'hF, 0, 0, 1, 0); idle(4'hF, 0, 1, 1, 1); idle(4'hF, 0, 0, 1, 0);
    add(1, 0, CMD_PERIOD, 2, 0, 4'hF, 0, 1, 1, 1);
    idle(4'hF, 0, 0, 1, 0); idle(4'hF, 0, 1, 1, 2);
    add(1, 0, CMD_STOP, 0, 0, 4'hF, 0, 0, 0, 2);
    idle(4'hF, 0, 0, 0, 2);
    // Gating: P=5 with en[0] low for two cycles
    add(1, 0, CMD_START, 5, 0, 4'hF, 0, 0, 1, 5);
    idle(4'hF, 0, 0, 1, 4); idle(4'hF, 0, 0, 1, 3); idle(4'hE, 0, 0, 1, 3);
    idle(4'hE, 0, 0, 1, 3); idle(4'hF, 0, 0, 1, 2); idle(4'hF, 0, 0, 1, 1);
    idle(4'hF, 0, 0, 1, 0); idle(4'hF, 0, 1, 1, 5);
    add(1, 0, CMD_STOP, 0, 0, 4'hF, 0, 0, 0, 5);
    // One-shot P=2 on ch1
    add(1, 1, CMD_START, 2, 1, 4'hF, 1, 0, 2, 2);
    idle(4'hF, 1, 0, 2, 1); idle(4'hF, 1, 0, 2, 0); idle(4'hF, 1, 2, 0, 0);
    idle(4'hF, 1, 0, 0, 0); idle(4'hF, 1, 0, 0, 0);
    // START on ch2 exactly when its count is 0
    add(1, 2, CMD_START, 1, 0, 4'hF, 2, 0, 4, 1);
    idle(4'hF, 2, 0, 4, 0);
    add(1, 2, CMD_START, 4, 0, 4'hF, 2, 0, 4, 4);
    idle(4'hF, 2, 0, 4, 3);
    // STOP freezes ch3 while ch2 keeps running
    add(1, 3, CMD_START, 6, 0, 4'hF, 3, 0, 4'hC, 6);
    idle(4'hF, 3, 0, 4'hC, 5);
    add(1, 3, CMD_STOP, 0, 0, 4'hF, 3, 0, 4, 5);
    idle(4'hF, 3, 4, 4, 5); idle(4'hF, 3, 0, 4, 5);

    // Reset state and cfg_ready timing
    step(); step(); step();
    chk("rst ready", {63'd0, cfg_ready}, 64'd0);
    chk("rst count", count, 64'd0);
    chk("rst tc_busy", {56'd0, tc, busy}, 64'd0);
    rst = 1'b0;
    chk("ready before edge", {63'd0, cfg_ready}, 64'd0);
    step();
    chk("ready after edge", {63'd0, cfg_ready}, 64'd1);

    foreach (vecs[i]) begin
      cfg_valid = vecs[i].v; cfg_ch = vecs[i].ch; cfg_cmd = vecs[i].cmd;
      cfg_period = vecs[i].per; cfg_oneshot = vecs[i].os; en = vecs[i].en;
      step();
      chk($sformatf("row%0d tc", i), {60'd0, tc}, {60'd0, vecs[i].etc});
      chk($sformatf("row%0d busy", i), {60'd0, busy}, {60'd0, vecs[i].ebusy});
      chk($sformatf("row%0d count", i), {48'd0, count[vecs[i].kch*16 +: 16]},
          {48'd0, vecs[i].ecnt});
    end

    // Mid-run reset with a command held on the port: dropped during and right after reset
    rst = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_cmd = CMD_START;
    cfg_period = 16'd7; cfg_oneshot = 1'b0; en = 4'hF;
    step();
    chk("midrst ready", {63'd0, cfg_ready}, 64'd0);
    chk("midrst count", count, 64'd0);
    chk("midrst tc_busy", {56'd0, tc, busy}, 64'd0);
    rst = 1'b0;
    step();
    chk("postrst ready", {63'd0, cfg_ready}, 64'd1);
    chk("postrst busy", {60'd0, busy}, 64'd0);
    chk("postrst count", count, 64'd0);

    // ch3 exists in the 4-channel bank but is out of range for the 3-channel bank
    cfg_ch = 2'd3; cfg_period = 16'd2;
    step();
    cfg_valid = 1'b0;
    chk("oor main busy", {60'd0, busy}, 64'h8);
    chk("oor main count3", {48'd0, count[48 +: 16]}, 64'd2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("oor dut3 busy%0d", k), {61'd0, busy3}, 64'd0);
      chk($sformatf("oor dut3 tc%0d", k), {61'd0, tc3}, 64'd0);
      chk($sformatf("oor dut3 count%0d", k), {16'd0, count3}, 64'd0);
      step();
      chk($sformatf("oor main tc%0d", k), {60'd0, tc}, (k == 2) ? 64'h8 : 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
